// File: rtl/uart_pkg.sv
// Shared UART definitions: controller state encoding, status word bit positions
// and the bit-period helper used by the receiver, transmitter and controller.
package uart_pkg;

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } rx_state_e;

   localparam int EMPTY_BIT = 15;
   localparam int OVF_BIT   = 14;

   function automatic int bit_period(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// CPU/receiver-facing signal bundle of the UART receive controller.
// master = receiver + CPU side, slave = the controller.
interface uart_rx_ctrl_if #(
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [15:0]   rx_out;
   logic          rx_ready;
   logic          rx_clear;
   logic          rd_en;
   logic          flush;
   logic          ovf_clr;
   logic [15:0]   out;
   logic [CW-1:0] count;
   logic          overflow;
   logic          idle;

   modport master (
      output rx_out, rx_ready, rd_en, flush, ovf_clr,
      input  rx_clear, out, count, overflow, idle
   );

   modport slave (
      input  rx_out, rx_ready, rd_en, flush, ovf_clr,
      output rx_clear, out, count, overflow, idle
   );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head output; a push into a full FIFO
// is accepted only when a pop frees the slot in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && (!full || do_pop) && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
         if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= din;
   end

   assign dout  = mem[rd_ptr_reg];
   assign count = count_reg;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: edge-detected byte capture into a FIFO, Hack-style status
// word, receiver clear sequencing, sticky overflow. Idle timer under UART_RX_CTRL_TIMEOUT_EN.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int CLK_FREQ   = 100000000,
   parameter int BAUD_RATE  = 115200,
   parameter int IDLE_BYTES = 2,
   parameter int CLR_CYCLES = 2
) (
   input  logic          CLK_100MHz,
   input  logic          clear,
   uart_rx_ctrl_if.slave bus
);
   localparam int CW          = $clog2(DEPTH) + 1;
   localparam int CLR_W       = $clog2(CLR_CYCLES + 1);
   localparam int IDLE_THRESH = IDLE_BYTES * 10 * bit_period(CLK_FREQ, BAUD_RATE);

   rx_state_e        state_reg, state_next;
   logic [CLR_W-1:0] clr_cnt_reg, clr_cnt_next;
   logic             rx_clear_reg;
   logic             rdy_s_reg, rdy_q_reg;
   logic [8:0]       data_s_reg;
   logic             overflow_reg, overflow_next;
   logic             fifo_flush;
   logic             push_evt, pop_req, ovf_set;
   logic             fifo_full, fifo_empty;
   logic [7:0]       fifo_head;
   logic [CW-1:0]    fifo_count;
   logic [15:0]      out_word;
   logic             unused_rx_bits;

   assign unused_rx_bits = ^bus.rx_out[14:8];

   // Receiver outputs are registered first; the edge detect then compares
   // that stage against its own delayed copy, so a held rx_ready pushes once.
   always_ff @(posedge CLK_100MHz or posedge clear) begin
      if (clear) begin
         state_reg    <= INIT;
         clr_cnt_reg  <= '0;
         rx_clear_reg <= 1'b1;
         rdy_s_reg    <= 1'b0;
         rdy_q_reg    <= 1'b0;
         data_s_reg   <= '0;
         overflow_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         clr_cnt_reg  <= clr_cnt_next;
         rx_clear_reg <= (state_next != RUN);
         rdy_s_reg    <= bus.rx_ready;
         rdy_q_reg    <= rdy_s_reg;
         data_s_reg   <= {bus.rx_out[15], bus.rx_out[7:0]};
         overflow_reg <= overflow_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      clr_cnt_next = '0;
      fifo_flush   = 1'b0;
      unique case (state_reg)
         INIT, FLUSH: begin
            clr_cnt_next = clr_cnt_reg + CLR_W'(1);
            if (clr_cnt_reg == CLR_W'(CLR_CYCLES - 1)) begin
               state_next   = RUN;
               clr_cnt_next = '0;
            end
         end
         RUN: begin
            if (bus.flush) begin
               state_next = FLUSH;
               fifo_flush = 1'b1;
            end
         end
         default: state_next = INIT;
      endcase
   end

   assign push_evt = (state_reg == RUN) && !bus.flush &&
                     rdy_s_reg && !rdy_q_reg && !data_s_reg[8];
   assign pop_req  = (state_reg == RUN) && !bus.flush && bus.rd_en;
   assign ovf_set  = push_evt && fifo_full && !pop_req;

   always_comb begin
      overflow_next = overflow_reg;
      if (ovf_set)          overflow_next = 1'b1;
      else if (bus.ovf_clr) overflow_next = 1'b0;
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (CLK_100MHz),
      .rst   (clear),
      .push  (push_evt),
      .pop   (pop_req),
      .flush (fifo_flush),
      .din   (data_s_reg[7:0]),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      out_word            = '0;
      out_word[EMPTY_BIT] = fifo_empty;
      out_word[OVF_BIT]   = overflow_reg;
      if (!fifo_empty) out_word[7:0] = fifo_head;
   end

   assign bus.out      = out_word;
   assign bus.count    = fifo_count;
   assign bus.overflow = overflow_reg;
   assign bus.rx_clear = rx_clear_reg;

`ifdef UART_RX_CTRL_TIMEOUT_EN
   localparam int TMR_W = $clog2(IDLE_THRESH + 1);

   logic             armed_reg;
   logic [TMR_W-1:0] timer_reg;
   logic             idle_reg;
   logic             push_ok;

   assign push_ok = push_evt && (!fifo_full || pop_req);

   // Pulse lands exactly IDLE_THRESH edges after the push edge that zeroed the timer.
   always_ff @(posedge CLK_100MHz or posedge clear) begin
      if (clear) begin
         armed_reg <= 1'b0;
         timer_reg <= '0;
         idle_reg  <= 1'b0;
      end else begin
         idle_reg <= 1'b0;
         if (fifo_flush) begin
            armed_reg <= 1'b0;
            timer_reg <= '0;
         end else if (push_ok) begin
            armed_reg <= 1'b1;
            timer_reg <= '0;
         end else if (armed_reg) begin
            if (timer_reg == TMR_W'(IDLE_THRESH - 1)) begin
               idle_reg  <= 1'b1;
               armed_reg <= 1'b0;
            end else begin
               timer_reg <= timer_reg + TMR_W'(1);
            end
         end
      end
   end

   assign bus.idle = idle_reg;
`else
   logic unused_idle_cfg;

   assign unused_idle_cfg = (IDLE_THRESH == 0);
   assign bus.idle        = 1'b0;
`endif

endmodule
